// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding (EX/MEM, MEM/WB, WB->ID bypass) plus a
// sequential hazard controller for load-use stalls and taken-branch flushes.
// Optional feature macro: WB_HOLD_EN adds a one-entry registered write-back
// buffer as the lowest-priority bypass source for both ID and EX operands.
// The stall/flush controls depend on the current state and the current-cycle
// hazard inputs. They are not registered, because a hazard must act in the
// cycle it is detected. fsm_state exposes the controller state for debug.
module fwd_hazard_unit #(
    parameter int XLEN       = 32,
    parameter int RAW        = 5,
    parameter int NSRC       = 2,
    parameter int LOAD_LAT   = 1,
    parameter int BR_PENALTY = 1
) (
    input  logic                 cpu_clk,
    input  logic                 cpu_rst,
    input  logic [NSRC*RAW-1:0]  id_rs,
    input  logic [NSRC-1:0]      id_rs_vld,
    input  logic [NSRC*XLEN-1:0] id_rf_rdata,
    output logic [NSRC*XLEN-1:0] id_src_data,
    input  logic [NSRC*RAW-1:0]  ex_rs,
    input  logic [NSRC*XLEN-1:0] ex_rdata,
    output logic [NSRC*XLEN-1:0] ex_src_data,
    input  logic [RAW-1:0]       ex_rd,
    input  logic                 ex_we,
    input  logic                 ex_is_load,
    input  logic [RAW-1:0]       mem_rd,
    input  logic                 mem_we,
    input  logic                 mem_is_load,
    input  logic [XLEN-1:0]      mem_alu_res,
    input  logic [RAW-1:0]       wb_rd,
    input  logic                 wb_we,
    input  logic [XLEN-1:0]      wb_wdata,
    input  logic                 br_taken,
    output logic                 pc_stall,
    output logic                 if_id_stall,
    output logic                 id_ex_flush,
    output logic                 if_id_flush,
    output logic [31:0]          stall_cnt,
    output logic [1:0]           fsm_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Counter reload values: the cycles still to come after the triggering one.
    localparam logic [2:0] LD_CNT = 3'(LOAD_LAT - 1);
    localparam logic [2:0] BR_CNT = 3'(BR_PENALTY - 1);

    // Qualified producers; register 0 never forwards.
    logic mem_fwd_ok;
    logic wb_fwd_ok;
    assign mem_fwd_ok = mem_we && (mem_rd != '0) && !mem_is_load;
    assign wb_fwd_ok  = wb_we && (wb_rd != '0);

    // Lowest-priority bypass source: the write-back hold buffer.
    logic            hold_vld;
    logic [RAW-1:0]  hold_rd;
    logic [XLEN-1:0] hold_data;

`ifdef WB_HOLD_EN
    logic            hold_vld_q, hold_vld_d;
    logic [RAW-1:0]  hold_rd_q, hold_rd_d;
    logic [XLEN-1:0] hold_data_q, hold_data_d;

    // Capture every architecturally visible write-back, keep it until the next.
    always_comb begin
        hold_vld_d  = hold_vld_q;
        hold_rd_d   = hold_rd_q;
        hold_data_d = hold_data_q;
        if (wb_fwd_ok) begin
            hold_vld_d  = 1'b1;
            hold_rd_d   = wb_rd;
            hold_data_d = wb_wdata;
        end
    end

    // Hold buffer registers.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            hold_vld_q  <= 1'b0;
            hold_rd_q   <= '0;
            hold_data_q <= '0;
        end else begin
            hold_vld_q  <= hold_vld_d;
            hold_rd_q   <= hold_rd_d;
            hold_data_q <= hold_data_d;
        end
    end

    assign hold_vld  = hold_vld_q;
    assign hold_rd   = hold_rd_q;
    assign hold_data = hold_data_q;
`else
    assign hold_vld  = 1'b0;
    assign hold_rd   = '0;
    assign hold_data = '0;
`endif

    // Per-channel forwarding muxes and load-use compare.
    logic [NSRC-1:0] luh_ch;

    for (genvar k = 0; k < NSRC; k++) begin : g_ch
        logic [RAW-1:0] ex_rs_k;
        logic [RAW-1:0] id_rs_k;
        logic           ex_hit_a, ex_hit_b, ex_hit_h;
        logic           id_hit_b, id_hit_h;

        assign ex_rs_k  = ex_rs[k*RAW +: RAW];
        assign id_rs_k  = id_rs[k*RAW +: RAW];

        assign ex_hit_a = mem_fwd_ok && (ex_rs_k == mem_rd);
        assign ex_hit_b = wb_fwd_ok && (ex_rs_k == wb_rd);
        assign ex_hit_h = hold_vld && (ex_rs_k == hold_rd);
        assign id_hit_b = wb_fwd_ok && (id_rs_k == wb_rd);
        assign id_hit_h = hold_vld && (id_rs_k == hold_rd);

        assign ex_src_data[k*XLEN +: XLEN] = ex_hit_a ? mem_alu_res :
                                             ex_hit_b ? wb_wdata :
                                             ex_hit_h ? hold_data :
                                                        ex_rdata[k*XLEN +: XLEN];

        assign id_src_data[k*XLEN +: XLEN] = id_hit_b ? wb_wdata :
                                             id_hit_h ? hold_data :
                                                        id_rf_rdata[k*XLEN +: XLEN];

        // id_rs_vld only masks the hazard check, never the bypass.
        assign luh_ch[k] = id_rs_vld[k] && (id_rs_k == ex_rd);
    end

    logic luh;
    assign luh = ex_is_load && ex_we && (ex_rd != '0) && (|luh_ch);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Next-state, countdown and same-cycle stall/flush decode; branch beats load-use.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        id_ex_flush = 1'b0;
        if_id_flush = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (br_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (BR_CNT != 3'd0) begin
                        state_d = ST_FLUSH;
                        cnt_d   = BR_CNT;
                    end
                end else if (luh) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                    if (LD_CNT != 3'd0) begin
                        state_d = ST_STALL;
                        cnt_d   = LD_CNT;
                    end
                end
            end
            ST_STALL: begin
                if (br_taken) begin
                    // A taken branch aborts the stall and starts the flush.
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (BR_CNT != 3'd0) begin
                        state_d = ST_FLUSH;
                        cnt_d   = BR_CNT;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = 3'd0;
                    end
                end else begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                    if (cnt_q <= 3'd1) begin
                        state_d = ST_IDLE;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d   = cnt_q - 3'd1;
                    end
                end
            end
            ST_FLUSH: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (br_taken) begin
                    // A new taken branch restarts the penalty window.
                    if (BR_CNT != 3'd0) begin
                        cnt_d   = BR_CNT;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = 3'd0;
                    end
                end else if (cnt_q <= 3'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d   = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
        // Controls are quiet for as long as reset is held.
        if (cpu_rst) begin
            pc_stall    = 1'b0;
            if_id_stall = 1'b0;
            id_ex_flush = 1'b0;
            if_id_flush = 1'b0;
        end
    end

    // Saturating count of cycles with the PC held.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pc_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Controller state, countdown and stall counter registers.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed vectors for forwarding and the hazard controller.
// The driver sets inputs just after each rising edge and queues the outputs it
// expects for that cycle. The monitor drains the queue on the falling edge.
module tb_fwd_hazard_unit;
  localparam int XLEN       = 32;
  localparam int RAW        = 5;
  localparam int NSRC       = 2;
  localparam int LOAD_LAT   = 2;
  localparam int BR_PENALTY = 3;

  // selectors for the checked outputs
  localparam int S_EX0   = 0;
  localparam int S_EX1   = 1;
  localparam int S_ID0   = 2;
  localparam int S_ID1   = 3;
  localparam int S_FLAGS = 4;
  localparam int S_SCNT  = 5;
  localparam int S_STATE = 6;

  // ---------------- clock / reset ----------------
  logic cpu_clk = 1'b0;
  logic cpu_rst = 1'b1;
  always #5 cpu_clk = ~cpu_clk;

  logic [NSRC*RAW-1:0]  id_rs;
  logic [NSRC-1:0]      id_rs_vld;
  logic [NSRC*XLEN-1:0] id_rf_rdata;
  logic [NSRC*XLEN-1:0] id_src_data;
  logic [NSRC*RAW-1:0]  ex_rs;
  logic [NSRC*XLEN-1:0] ex_rdata;
  logic [NSRC*XLEN-1:0] ex_src_data;
  logic [RAW-1:0]       ex_rd;
  logic                 ex_we;
  logic                 ex_is_load;
  logic [RAW-1:0]       mem_rd;
  logic                 mem_we;
  logic                 mem_is_load;
  logic [XLEN-1:0]      mem_alu_res;
  logic [RAW-1:0]       wb_rd;
  logic                 wb_we;
  logic [XLEN-1:0]      wb_wdata;
  logic                 br_taken;
  logic                 pc_stall;
  logic                 if_id_stall;
  logic                 id_ex_flush;
  logic                 if_id_flush;
  logic [31:0]          stall_cnt;
  logic [1:0]           fsm_state;

  fwd_hazard_unit #(
    .XLEN(XLEN), .RAW(RAW), .NSRC(NSRC),
    .LOAD_LAT(LOAD_LAT), .BR_PENALTY(BR_PENALTY)
  ) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .id_rs(id_rs), .id_rs_vld(id_rs_vld), .id_rf_rdata(id_rf_rdata),
    .id_src_data(id_src_data),
    .ex_rs(ex_rs), .ex_rdata(ex_rdata), .ex_src_data(ex_src_data),
    .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_is_load(mem_is_load),
    .mem_alu_res(mem_alu_res),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_wdata(wb_wdata),
    .br_taken(br_taken),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .id_ex_flush(id_ex_flush), .if_id_flush(if_id_flush),
    .stall_cnt(stall_cnt), .fsm_state(fsm_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    int              sel;
    int              vec;
    logic [XLEN-1:0] exp;
  } chk_t;

  chk_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vec   = 0;

  function automatic logic [XLEN-1:0] actual(input int sel);
    case (sel)
      S_EX0:   return ex_src_data[0 +: XLEN];
      S_EX1:   return ex_src_data[XLEN +: XLEN];
      S_ID0:   return id_src_data[0 +: XLEN];
      S_ID1:   return id_src_data[XLEN +: XLEN];
      S_FLAGS: return {28'd0, pc_stall, if_id_stall, id_ex_flush, if_id_flush};
      S_SCNT:  return stall_cnt;
      S_STATE: return {30'd0, fsm_state};
      default: return '0;
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      S_EX0:   return "ex_src_data.ch0";
      S_EX1:   return "ex_src_data.ch1";
      S_ID0:   return "id_src_data.ch0";
      S_ID1:   return "id_src_data.ch1";
      S_FLAGS: return "flags{pc_stall,if_id_stall,id_ex_flush,if_id_flush}";
      S_SCNT:  return "stall_cnt";
      S_STATE: return "fsm_state";
      default: return "unknown";
    endcase
  endfunction

  // monitor: everything queued during this cycle is compared mid-cycle
  always @(negedge cpu_clk) begin
    chk_t c;
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      n_cmp++;
      if (actual(c.sel) !== c.exp) begin
        n_bad++;
        $display("FAIL %s vec=%0d actual=%h expected=%h",
                 sel_name(c.sel), c.vec, actual(c.sel), c.exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_defaults();
    id_rs       = '0;
    id_rs_vld   = '0;
    id_rf_rdata = '0;
    ex_rs       = '0;
    ex_rdata    = '0;
    ex_rd       = '0;
    ex_we       = 1'b0;
    ex_is_load  = 1'b0;
    mem_rd      = '0;
    mem_we      = 1'b0;
    mem_is_load = 1'b0;
    mem_alu_res = '0;
    wb_rd       = '0;
    wb_we       = 1'b0;
    wb_wdata    = '0;
    br_taken    = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge cpu_clk);
    #1;
    set_defaults();
    vec++;
  endtask

  task automatic expect_val(input int sel, input logic [XLEN-1:0] v);
    chk_t c;
    c.sel = sel;
    c.vec = vec;
    c.exp = v;
    exp_q.push_back(c);
  endtask

  task automatic expect_flags(input logic [3:0] f);
    expect_val(S_FLAGS, {28'd0, f});
  endtask

  task automatic drive_load_use();
    ex_is_load = 1'b1;
    ex_we      = 1'b1;
    ex_rd      = 5'd7;
    id_rs      = {5'd7, 5'd0};
    id_rs_vld  = 2'b11;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_defaults();
    cpu_rst = 1'b1;

    // reset state
    next_cycle();
    expect_flags(4'b0000);
    expect_val(S_SCNT, 32'd0);
    expect_val(S_STATE, 32'd0);
    cpu_rst = 1'b0;

    // ALU chain: x5=7 in MEM, ID/EX holds stale 0
    next_cycle();
    mem_rd = 5'd5; mem_we = 1'b1; mem_alu_res = 32'd7;
    ex_rs = {5'd0, 5'd5};
    expect_val(S_EX0, 32'd7);
    expect_flags(4'b0000);

    // MEM beats WB on the same register
    next_cycle();
    wb_rd = 5'd6; wb_we = 1'b1; wb_wdata = 32'd1;
    mem_rd = 5'd6; mem_we = 1'b1; mem_alu_res = 32'd2;
    ex_rs = {5'd3, 5'd6}; ex_rdata = {32'h22, 32'h11};
    expect_val(S_EX0, 32'd2);
    expect_val(S_EX1, 32'h22);

    // MEM entry is a load: WB value wins
    next_cycle();
    wb_rd = 5'd6; wb_we = 1'b1; wb_wdata = 32'd1;
    mem_rd = 5'd6; mem_we = 1'b1; mem_is_load = 1'b1; mem_alu_res = 32'd2;
    ex_rs = {5'd6, 5'd6}; ex_rdata = {32'h22, 32'h11};
    expect_val(S_EX0, 32'd1);
    expect_val(S_EX1, 32'd1);

    // WB->ID bypass on ch0 only
    next_cycle();
    wb_rd = 5'd4; wb_we = 1'b1; wb_wdata = 32'hABC;
    id_rs = {5'd8, 5'd4}; id_rf_rdata = {32'h200, 32'h100};
    expect_val(S_ID0, 32'hABC);
    expect_val(S_ID1, 32'h200);

    // x0 is never forwarded
    next_cycle();
    wb_rd = 5'd0; wb_we = 1'b1; wb_wdata = 32'hDEAD;
    mem_rd = 5'd0; mem_we = 1'b1; mem_alu_res = 32'h99;
    id_rs = {5'd0, 5'd0}; id_rf_rdata = {32'h0, 32'h0};
    ex_rs = {5'd0, 5'd0}; ex_rdata = {32'h6, 32'h5};
    expect_val(S_ID0, 32'h0);
    expect_val(S_EX0, 32'h5);
    expect_val(S_EX1, 32'h6);

    // load-use masked by id_rs_vld
    next_cycle();
    drive_load_use();
    id_rs_vld = 2'b01;
    expect_flags(4'b0000);
    expect_val(S_SCNT, 32'd0);

    // load-use: stall for LOAD_LAT=2 cycles
    next_cycle();
    drive_load_use();
    expect_flags(4'b1110);
    expect_val(S_SCNT, 32'd0);
    next_cycle();
    drive_load_use();
    expect_flags(4'b1110);
    expect_val(S_SCNT, 32'd1);
    expect_val(S_STATE, 32'd1);
    next_cycle();
    expect_flags(4'b0000);
    expect_val(S_SCNT, 32'd2);

    // branch pulse: flush BR_PENALTY=3 cycles
    next_cycle();
    br_taken = 1'b1;
    expect_flags(4'b0011);
    next_cycle();
    expect_flags(4'b0011);
    next_cycle();
    expect_flags(4'b0011);
    next_cycle();
    expect_flags(4'b0000);

    // branch during a load stall aborts it; load-use ignored while flushing
    next_cycle();
    drive_load_use();
    expect_flags(4'b1110);
    expect_val(S_SCNT, 32'd2);
    next_cycle();
    drive_load_use();
    br_taken = 1'b1;
    expect_flags(4'b0011);
    expect_val(S_SCNT, 32'd3);
    next_cycle();
    drive_load_use();
    expect_flags(4'b0011);
    expect_val(S_SCNT, 32'd3);
    next_cycle();
    expect_flags(4'b0011);
    next_cycle();
    expect_flags(4'b0000);
    expect_val(S_SCNT, 32'd3);

    // branch while flushing reloads the countdown
    next_cycle();
    br_taken = 1'b1;
    expect_flags(4'b0011);
    next_cycle();
    expect_flags(4'b0011);
    next_cycle();
    br_taken = 1'b1;
    expect_flags(4'b0011);
    next_cycle();
    expect_flags(4'b0011);
    next_cycle();
    expect_flags(4'b0011);
    next_cycle();
    expect_flags(4'b0000);

    // reset asserted mid-stall
    next_cycle();
    drive_load_use();
    expect_flags(4'b1110);
    expect_val(S_SCNT, 32'd3);
    next_cycle();
    drive_load_use();
    cpu_rst = 1'b1;
    expect_flags(4'b0000);
    expect_val(S_SCNT, 32'd0);
    expect_val(S_STATE, 32'd0);
    next_cycle();
    cpu_rst = 1'b0;
    expect_flags(4'b0000);
    expect_val(S_SCNT, 32'd0);

    // write-back hold: x9=0x55 written, read back next cycle with stale RF data
    next_cycle();
    wb_rd = 5'd9; wb_we = 1'b1; wb_wdata = 32'h55;
    next_cycle();
    id_rs = {5'd0, 5'd9}; id_rf_rdata = {32'h0, 32'h0};
    ex_rs = {5'd9, 5'd0}; ex_rdata = {32'h3, 32'h0};
`ifdef WB_HOLD_EN
    expect_val(S_ID0, 32'h55);
    expect_val(S_EX1, 32'h55);
`else
    expect_val(S_ID0, 32'h0);
    expect_val(S_EX1, 32'h3);
`endif

    // let the monitor drain the last cycle
    next_cycle();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain actual=%0d pending expected=0 pending", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
